// File: rtl/lcd_cmd_issuer.sv
// Command sequencer feeding LCD_CTRL: buffers host opcodes in a FIFO and issues
// them one at a time under the busy handshake, halting for good after a Write.
module lcd_cmd_issuer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       host_cmd,
    input  logic             host_valid,
    output logic             host_ready,
    output logic [3:0]       cmd,
    output logic             cmd_valid,
    input  logic             busy,
    input  logic             done,
    output logic             halted,
    output logic             finished,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] STAT_MAX = '1;
    localparam logic [3:0]       OP_WRITE = 4'd0;
    localparam logic [3:0]       OP_LAST  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HALT
    } state_t;

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic drop;
    logic pop;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign host_ready = !full && !halted;
    assign accept     = host_valid && host_ready;
    assign push       = accept && (host_cmd <= OP_LAST);
    assign drop       = accept && (host_cmd > OP_LAST);
    assign pop        = (state == IDLE) && !busy && !empty && !halted;

    // NOTE: the storage array has no reset; entries are only read behind count,
    // so clearing the pointers and count is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= host_cmd;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            halted     <= 1'b0;
            finished   <= 1'b0;
            issued_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;

            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (drop && drop_cnt != STAT_MAX)
                drop_cnt <= drop_cnt + STAT_ONE;

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        cmd       <= mem[rd_ptr];
                        cmd_valid <= 1'b1;
                        if (issued_cnt != STAT_MAX)
                            issued_cnt <= issued_cnt + STAT_ONE;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_valid <= 1'b0;
                    if (cmd == OP_WRITE) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state  <= WAIT;
                    end
                end
                // Guard cycle: LCD_CTRL's registered busy becomes visible before IDLE re-checks it.
                WAIT: state <= IDLE;
                HALT: begin
                    if (done)
                        finished <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Scoreboard bench for lcd_cmd_issuer: expected opcodes are queued as they are
// pushed and compared whenever the DUT raises cmd_valid.
module tb_lcd_cmd_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       halted;
    logic       finished;
    logic [7:0] issued_cnt;
    logic [7:0] drop_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];
    int         pulse_cnt  = 0;
    int         cyc        = 0;
    int         last_pulse = -1;
    bit         chk_gap    = 0;
    logic       prev_cv    = 1'b0;
    logic       prev_busy  = 1'b0;

    lcd_cmd_issuer #(.DEPTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .host_cmd  (host_cmd),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .done      (done),
        .halted    (halted),
        .finished  (finished),
        .issued_cnt(issued_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every cmd_valid cycle pops one expected opcode.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            last_pulse = -1;
        end else if (cmd_valid) begin
            pulse_cnt++;
            check("pulse_width", prev_cv, 0);
            check("issued_while_busy", prev_busy, 0);
            check("scoreboard_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("cmd", cmd, exp_q.pop_front());
            if (chk_gap && last_pulse >= 0)
                check("issue_spacing", cyc - last_pulse, 3);
            last_pulse = cyc;
        end
        prev_cv   = cmd_valid && !reset;
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input logic [3:0] op, input bit will_issue);
        int n = 0;
        host_cmd   = op;
        host_valid = 1'b1;
        while (!host_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", host_ready, 1);
        tick();
        host_valid = 1'b0;
        if (will_issue)
            exp_q.push_back(op);
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, pulse_cnt, target);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        int base;

        // Reset state and basic issue: 3, 9, 0 with 3-cycle spacing.
        do_reset();
        check("rst_cmd", cmd, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_finished", finished, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_host_ready", host_ready, 1);
        chk_gap = 1;
        base = pulse_cnt;
        push(4'd3, 1);
        check("latency_pre", cmd_valid, 0);
        tick();
        check("latency_k1", cmd_valid, 1);
        push(4'd9, 1);
        push(4'd0, 1);
        wait_pulses("basic_drain", base + 3, 40);
        idle_cycles(3);
        chk_gap = 0;
        check("basic_halted", halted, 1);
        check("basic_host_ready", host_ready, 0);
        check("basic_issued", issued_cnt, 3);

        // Busy stall: nothing issues while busy, first pulse right after release.
        do_reset();
        busy = 1'b1;
        base = pulse_cnt;
        push(4'd1, 1);
        push(4'd2, 1);
        push(4'd5, 1);
        idle_cycles(17);
        check("stall_no_issue", pulse_cnt, base);
        busy = 1'b0;
        tick();
        check("stall_release_valid", cmd_valid, 1);
        check("stall_release_cmd", cmd, 1);
        wait_pulses("stall_drain", base + 3, 40);
        idle_cycles(4);
        check("stall_issued", issued_cnt, 3);

        // Full FIFO: 10 back-to-back offers, only 8 accepted.
        do_reset();
        busy = 1'b1;
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            host_cmd   = 4'(i + 1);
            host_valid = 1'b1;
            check("full_ready", host_ready, i < 8);
            if (i < 8)
                exp_q.push_back(4'(i + 1));
            tick();
        end
        host_valid = 1'b0;
        check("full_ready_after", host_ready, 0);
        busy = 1'b0;
        wait_pulses("full_drain", base + 8, 60);
        idle_cycles(10);
        check("full_exact", pulse_cnt, base + 8);
        check("full_issued", issued_cnt, 8);
        check("full_ready_drained", host_ready, 1);

        // Illegal opcodes are dropped and counted.
        do_reset();
        base = pulse_cnt;
        push(4'd12, 0);
        push(4'd4, 1);
        push(4'd15, 0);
        wait_pulses("illegal_drain", base + 1, 20);
        idle_cycles(6);
        check("illegal_exact", pulse_cnt, base + 1);
        check("illegal_drop", drop_cnt, 2);
        check("illegal_issued", issued_cnt, 1);

        // Halt after Write with commands still queued, then done.
        do_reset();
        busy = 1'b1;
        base = pulse_cnt;
        push(4'd0, 1);
        push(4'd5, 0);
        push(4'd6, 0);
        busy = 1'b0;
        wait_pulses("halt_issue", base + 1, 20);
        idle_cycles(3);
        check("halt_halted", halted, 1);
        check("halt_finished_pre", finished, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        idle_cycles(10);
        check("halt_finished_sticky", finished, 1);
        check("halt_no_more", pulse_cnt, base + 1);
        check("halt_ready", host_ready, 0);
        do_reset();
        check("halt_rst_finished", finished, 0);
        check("halt_rst_halted", halted, 0);
        base = pulse_cnt;
        idle_cycles(10);
        check("halt_rst_empty", pulse_cnt, base);
        push(4'd7, 1);
        wait_pulses("halt_rst_fresh", base + 1, 20);

        // Reset during the cmd_valid cycle.
        do_reset();
        base = pulse_cnt;
        push(4'd2, 1);
        tick();
        check("midissue_valid", cmd_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("midissue_valid_after", cmd_valid, 0);
        check("midissue_issued", issued_cnt, 0);
        check("midissue_ready", host_ready, 1);
        idle_cycles(10);
        check("midissue_empty", pulse_cnt, base);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_issuer.md
# lcd_cmd_issuer

Command sequencer directly upstream of LCD_CTRL. It buffers 4-bit image-operation commands from a host into a FIFO and issues them one at a time on the `cmd`/`cmd_valid` pair, honouring LCD_CTRL's `busy` handshake. After a Write command (opcode 0) it stops issuing, latches LCD_CTRL's `done`, and stays halted until reset. It replaces the hand-driven command stimulus in system-level runs.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `CNT_W`, 8: width of `issued_cnt` and `drop_cnt`; counters saturate at all-ones.

- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high; clears all state at the next rising edge.
- `host_cmd`  in  4: command opcode from host.
- `host_valid`  in  1: host offers `host_cmd` this cycle.
- `host_ready`  out  1: combinational, `!full && !halted`; a push occurs on an edge where `host_valid && host_ready`.
- `cmd`  out  4: registered opcode to LCD_CTRL.
- `cmd_valid`  out  1: registered, high for exactly one cycle per issued command.
- `busy`  in  1: LCD_CTRL busy.
- `done`  in  1: LCD_CTRL completion.
- `halted`  out  1: registered; set once a Write has been issued.
- `finished`  out  1: registered; sticky copy of `done`, captured while `halted`.
- `issued_cnt`  out  CNT_W: commands issued since reset.
- `drop_cnt`  out  CNT_W: illegal opcodes discarded since reset.

## Operation
- Legal opcodes are 0–11: 0 write, 1–4 shift up/down/left/right, 5 max, 6 min, 7 average, 8 CCW rotate, 9 CW rotate, 10 mirror X, 11 mirror Y.
- Opcodes 12–15 are accepted when pushed, because `host_ready` does not depend on the value. They are not stored, and `drop_cnt` increments instead.
- The FIFO has registered read/write pointers plus an occupancy count of width log2(DEPTH)+1. `full` means count==DEPTH; `empty` means count==0. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE
    - If `!busy && !empty && !halted`: pop the head into `cmd`, set `cmd_valid`=1, increment `issued_cnt`, go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: `cmd_valid` is high during this cycle.
    - Next edge: clear `cmd_valid`.
    - If `cmd` is 0: set `halted`, go to HALT.
    - Otherwise go to WAIT.
  - WAIT: a guard cycle so LCD_CTRL's registered `busy` becomes visible.
    - Next edge: go to IDLE unconditionally.
    - IDLE then re-checks `busy`. The earliest next issue is 3 edges after the previous one.
  - HALT: terminal state.
    - No pops; pushes are refused.
    - `finished` is set on the first edge where `done`=1.
    - Only `reset` leaves HALT.
- Commands still in the FIFO when Write issues remain unissued; they are cleared by reset.
- Push and pop in the same edge: count is unchanged and both pointers advance.
- No bypass from push to pop: a push into an empty FIFO is not visible to IDLE until the following edge.
- A push is refused when full, even if a pop occurs on the same edge.
- `busy` high at power-up, e.g. during LCD_CTRL image load, holds the FSM in IDLE; commands accumulate in the FIFO.

## Timing
- State after reset:
  - `cmd`=0, `cmd_valid`=0, `halted`=0, `finished`=0, both counters 0.
  - FIFO empty, FSM in IDLE.
  - `host_ready`=1 in the first cycle after reset.
- `reset` asserted mid-operation (including ISSUE or HALT) overrides every other update at that edge.
- Latency:
  - Command pushed at edge k into an empty FIFO, with `busy` low: `cmd_valid` is high in the cycle after edge k+1.
  - LCD_CTRL samples `cmd` at edge k+2.
- `cmd` holds its last value after `cmd_valid` falls; it is only meaningful while `cmd_valid`=1.
- Counters stop at 2^CNT_W−1 and never wrap.

## Test plan
- **Reset and basic issue.** Reset, `busy`=0, push 3, 9, 0.
  - Expect 3 one-cycle `cmd_valid` pulses carrying 3, 9, 0, spaced 3 cycles apart.
  - Then `halted`=1, `host_ready`=0, `issued_cnt`=3.
- **Busy stall.** Hold `busy`=1 for 20 cycles while pushing 1, 2, 5, then release.
  - Expect no `cmd_valid` while `busy`=1.
  - First pulse (`cmd`=1) appears 1 cycle after `busy` falls, observed at the IDLE edge.
- **Full FIFO.** `busy`=1, push 10 commands with DEPTH=8.
  - Expect `host_ready`=0 after the 8th push; pushes 9 and 10 are not accepted.
  - After `busy` falls, exactly 8 commands issue in order.
- **Illegal opcodes.** Push 12, 4, 15.
  - Expect only `cmd`=4 issued, `drop_cnt`=2, `issued_cnt`=1.
- **Halt and done.** Issue write (0) with 2 more commands queued, then pulse `done` for 1 cycle.
  - Expect `finished`=1 sticky and no further `cmd_valid`.
  - After reset, the FIFO is empty and `finished`=0.
- **Reset mid-ISSUE.** Assert `reset` during the `cmd_valid` cycle.
  - Expect `cmd_valid`=0 and `issued_cnt`=0 on the next cycle, and the FIFO empty.
